// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded hold time.
// Registered owner index, grant valid and hold counter feed decoder_2_4.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  output logic [1:0]    gnt_idx,
  output logic          gnt_en,
  output logic [HW-1:0] hold_cnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HONE = HW'(1);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] others;
  logic [1:0] pick_idle;
  logic [1:0] pick_next;
  logic [1:0] pick_pre;
  logic       is_rel;
  logic       is_pre;

  function automatic logic [1:0] search(
    input logic [1:0] start,
    input logic [3:0] mask
  );
    logic [1:0] idx;
    logic [1:0] pick;
    logic       hit;
    pick = start;
    hit  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!hit && mask[idx]) begin
        pick = idx;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  // candidate owners for each transition, all searched from the edge-sampled req
  always_comb begin
    others    = req & ~(4'b0001 << gnt_idx);
    pick_idle = search(ptr, req);
    pick_next = search(gnt_idx + 2'd1, req);
    pick_pre  = search(gnt_idx + 2'd1, others);
    is_rel    = !req[gnt_idx];
    is_pre    = (hold_cnt == HMAX) && (|others);
  end

  // arbiter state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      gnt_idx  <= 2'd0;
      gnt_en   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            gnt_idx  <= pick_idle;
            gnt_en   <= 1'b1;
            hold_cnt <= HONE;
            ptr      <= pick_idle + 2'd1;
          end
        end
        GRANT: begin
          unique case (1'b1)
            is_rel && (|req): begin
              gnt_idx  <= pick_next;
              hold_cnt <= HONE;
              ptr      <= pick_next + 2'd1;
            end
            is_rel && !(|req): begin
              state    <= IDLE;
              gnt_en   <= 1'b0;
              hold_cnt <= '0;
            end
            !is_rel && is_pre: begin
              gnt_idx  <= pick_pre;
              hold_cnt <= HONE;
              ptr      <= pick_pre + 2'd1;
            end
            default: begin
              if (hold_cnt != HMAX) hold_cnt <= hold_cnt + HONE;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4.
// Vector table plus hand-written multi-cycle sequences.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic       gnt_en;
  logic [3:0] hold_cnt;
  logic [3:0] req1;
  logic [1:0] gnt_idx1;
  logic       gnt_en1;
  logic [0:0] hold1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic [1:0] idx;
    logic [3:0] hold;
  } vec_t;

  vec_t tbl [15];

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .gnt_idx(gnt_idx),
    .gnt_en(gnt_en),
    .hold_cnt(hold_cnt)
  );

  rr_arbiter_4 #(.MAX_HOLD(1)) dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .req(req1),
    .gnt_idx(gnt_idx1),
    .gnt_en(gnt_en1),
    .hold_cnt(hold1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0000;
    req1 = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] dout;

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    req1  = 4'b0000;

    // reset holds outputs low even with full request load
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", int'(gnt_en), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_hold", int'(hold_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // full-load rotation: 8 cycles per owner, 0,1,2,3,0
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      chk("full_en", int'(gnt_en), 1);
      chk("full_idx", int'(gnt_idx), ((k - 1) / 8) % 4);
      chk("full_hold", int'(hold_cnt), ((k - 1) % 8) + 1);
    end

    // vector table, starting from a fresh reset (ptr=0)
    tbl[0]  = '{4'b0100, 1'b1, 2'd2, 4'd1};
    tbl[1]  = '{4'b0000, 1'b0, 2'd0, 4'd0};
    tbl[2]  = '{4'b0110, 1'b1, 2'd1, 4'd1};
    tbl[3]  = '{4'b0110, 1'b1, 2'd1, 4'd2};
    tbl[4]  = '{4'b0100, 1'b1, 2'd2, 4'd1};
    tbl[5]  = '{4'b1100, 1'b1, 2'd2, 4'd2};
    tbl[6]  = '{4'b1000, 1'b1, 2'd3, 4'd1};
    tbl[7]  = '{4'b1001, 1'b1, 2'd3, 4'd2};
    tbl[8]  = '{4'b0001, 1'b1, 2'd0, 4'd1};
    tbl[9]  = '{4'b0000, 1'b0, 2'd0, 4'd0};
    tbl[10] = '{4'b1010, 1'b1, 2'd1, 4'd1};
    tbl[11] = '{4'b1000, 1'b1, 2'd3, 4'd1};
    tbl[12] = '{4'b0000, 1'b0, 2'd0, 4'd0};
    tbl[13] = '{4'b1111, 1'b1, 2'd0, 4'd1};
    tbl[14] = '{4'b0000, 1'b0, 2'd0, 4'd0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].req);
      dout = gnt_en ? (4'b0001 << gnt_idx) : 4'b0000;
      chk($sformatf("vec%0d_en", i), int'(gnt_en), int'(tbl[i].en));
      chk($sformatf("vec%0d_hold", i), int'(hold_cnt), int'(tbl[i].hold));
      if (tbl[i].en) begin
        chk($sformatf("vec%0d_idx", i), int'(gnt_idx), int'(tbl[i].idx));
        chk($sformatf("vec%0d_dout", i), int'(dout),
            int'(4'b0001 << tbl[i].idx));
      end
    end

    // sole requester keeps grant; hold saturates at 8
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step(4'b0001);
      chk("sole_en", int'(gnt_en), 1);
      chk("sole_idx", int'(gnt_idx), 0);
      chk("sole_hold", int'(hold_cnt), (k < 8) ? k : 8);
    end
    step(4'b1001);
    chk("sole_pre_idx", int'(gnt_idx), 3);
    chk("sole_pre_hold", int'(hold_cnt), 1);
    chk("sole_pre_en", int'(gnt_en), 1);

    // async reset mid-grant, then priority restarts at 0
    do_reset();
    for (int k = 1; k <= 17; k++) step(4'b1111);
    chk("mid_idx", int'(gnt_idx), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", int'(gnt_en), 0);
    chk("mid_rst_idx", int'(gnt_idx), 0);
    chk("mid_rst_hold", int'(hold_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_post_en", int'(gnt_en), 1);
    chk("mid_post_idx", int'(gnt_idx), 0);

    // MAX_HOLD=1 rotates every cycle under full load
    do_reset();
    @(negedge clk);
    req1 = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk("mh1_en", int'(gnt_en1), 1);
      chk("mh1_idx", int'(gnt_idx1), (k - 1) % 4);
      chk("mh1_hold", int'(hold1), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
